// File: rtl/cache_arbiter_pkg.sv
// Shared types for the cache arbiter: FSM states, grant identity, and a
// helper that maps a grant onto the matching service state.
package cache_arb_types;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2,
      DONE    = 2'd3
   } arb_state_t;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } grant_t;

   function automatic arb_state_t serve_state(input grant_t g);
      return (g == GRANT_D) ? SERVE_D : SERVE_I;
   endfunction

endpackage

// File: rtl/cache_arbiter_pmem_mux.sv
// Memory-side output mux: routes the granted cache's request onto the
// physical memory port. Everything is zero outside the two SERVE states.
module arb_pmem_mux
   import cache_arb_types::*;
#(
   parameter int unsigned s_line = 256,
   parameter int unsigned s_addr = 32
) (
   input  arb_state_t          state,
   input  logic [s_addr-1:0]   i_pmem_address,
   input  logic                d_pmem_read,
   input  logic                d_pmem_write,
   input  logic [s_addr-1:0]   d_pmem_address,
   input  logic [s_line-1:0]   d_pmem_wdata,
   output logic                pmem_read,
   output logic                pmem_write,
   output logic [s_addr-1:0]   pmem_address,
   output logic [s_line-1:0]   pmem_wdata
);

   // Select the granted requester's bus; a dcache write overrides a read.
   always_comb begin
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      pmem_wdata   = '0;
      unique case (state)
         SERVE_I: begin
            pmem_read    = 1'b1;
            pmem_address = i_pmem_address;
         end
         SERVE_D: begin
            pmem_read    = d_pmem_read & ~d_pmem_write;
            pmem_write   = d_pmem_write;
            pmem_address = d_pmem_address;
            pmem_wdata   = d_pmem_wdata;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/cache_arbiter.sv
// Arbiter sharing one physical memory port between icache and dcache.
// One transaction outstanding; grant held until pmem_resp, followed by one
// turnaround cycle so a stale request in the resp cycle is never re-granted.
// Optional macro CACHE_ARBITER_DPRIO_EN: dcache wins every tie (fixed
// priority); otherwise ties are resolved round-robin on last_grant.
module cache_arbiter
   import cache_arb_types::*;
#(
   parameter int unsigned s_line = 256,
   parameter int unsigned s_addr = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_pmem_read,
   input  logic [s_addr-1:0]   i_pmem_address,
   output logic [s_line-1:0]   i_pmem_rdata,
   output logic                i_pmem_resp,
   input  logic                d_pmem_read,
   input  logic                d_pmem_write,
   input  logic [s_addr-1:0]   d_pmem_address,
   input  logic [s_line-1:0]   d_pmem_wdata,
   output logic [s_line-1:0]   d_pmem_rdata,
   output logic                d_pmem_resp,
   output logic                pmem_read,
   output logic                pmem_write,
   output logic [s_addr-1:0]   pmem_address,
   output logic [s_line-1:0]   pmem_wdata,
   input  logic [s_line-1:0]   pmem_rdata,
   input  logic                pmem_resp
);

   arb_state_t state_q, state_d;
   grant_t     last_grant_q, last_grant_d;
   grant_t     winner;
   logic       i_req, d_req;

   assign i_req = i_pmem_read;
   assign d_req = d_pmem_read | d_pmem_write;

   // State and last-grant registers; async reset returns to IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= GRANT_D;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Next-state: arbitrate in IDLE, hold grant until resp, one DONE cycle.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      winner       = GRANT_I;
      if (i_req && d_req) begin
`ifdef CACHE_ARBITER_DPRIO_EN
         winner = GRANT_D;
`else
         winner = (last_grant_q == GRANT_I) ? GRANT_D : GRANT_I;
`endif
      end else if (d_req) begin
         winner = GRANT_D;
      end
      unique case (state_q)
         IDLE: begin
            if (i_req || d_req) begin
               state_d      = serve_state(winner);
               last_grant_d = winner;
            end
         end
         SERVE_I, SERVE_D: begin
            if (pmem_resp) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs: resp gated to the granted cache only; read data shared.
   always_comb begin
      i_pmem_resp  = (state_q == SERVE_I) & pmem_resp;
      d_pmem_resp  = (state_q == SERVE_D) & pmem_resp;
      i_pmem_rdata = pmem_rdata;
      d_pmem_rdata = pmem_rdata;
   end

   arb_pmem_mux #(
      .s_line (s_line),
      .s_addr (s_addr)
   ) u_pmem_mux (
      .state          (state_q),
      .i_pmem_address (i_pmem_address),
      .d_pmem_read    (d_pmem_read),
      .d_pmem_write   (d_pmem_write),
      .d_pmem_address (d_pmem_address),
      .d_pmem_wdata   (d_pmem_wdata),
      .pmem_read      (pmem_read),
      .pmem_write     (pmem_write),
      .pmem_address   (pmem_address),
      .pmem_wdata     (pmem_wdata)
   );

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares the single 256-bit physical memory port between the instruction cache and the data cache.
- Sits between the two cache `pmem_*` interfaces and main memory.
- Serialises line fills and write-backs; one transaction is outstanding at a time.
- A small FSM chooses the requester and holds the grant until `pmem_resp`, then inserts one turnaround cycle.

Parameters:
- s_line, 256, cache line width in bits (width of every `*_rdata`/`*_wdata` bus)
- s_addr, 32, physical address width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- i_pmem_read  in  1  icache line fill request
- i_pmem_address  in  s_addr  icache line address, held stable until i_pmem_resp
- i_pmem_rdata  out  s_line  fill data to icache
- i_pmem_resp  out  1  icache transaction complete, one-cycle pulse
- d_pmem_read  in  1  dcache line fill request
- d_pmem_write  in  1  dcache write-back request
- d_pmem_address  in  s_addr  dcache line address, held stable until d_pmem_resp
- d_pmem_wdata  in  s_line  write-back data, held stable until d_pmem_resp
- d_pmem_rdata  out  s_line  fill data to dcache
- d_pmem_resp  out  1  dcache transaction complete, one-cycle pulse
- pmem_read  out  1  memory read
- pmem_write  out  1  memory write
- pmem_address  out  s_addr  memory address
- pmem_wdata  out  s_line  memory write data
- pmem_rdata  in  s_line  memory read data
- pmem_resp  in  1  memory completion pulse

Behaviour:
- Reset values:
  - state=IDLE, last_grant=D
  - pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0
  - i_pmem_resp=0, d_pmem_resp=0
- Requests:
  - i_req = i_pmem_read.
  - d_req = d_pmem_read | d_pmem_write.
  - If d_pmem_read and d_pmem_write are both high, the write wins; pmem_read is forced 0 for that transaction.
- State IDLE:
  - All pmem outputs are 0.
  - If exactly one requester is active, register a grant to it.
  - If both are active, grant the one that is not last_grant (round-robin).
  - Next state: SERVE_I or SERVE_D; last_grant updates to the winner.
  - No request: stay in IDLE.
  - A request sampled in cycle N produces pmem_read/pmem_write in cycle N+1 (one-cycle grant latency).
- State SERVE_I:
  - pmem_read=1, pmem_write=0, pmem_address=i_pmem_address (combinational mux).
- State SERVE_D:
  - pmem_read=d_pmem_read & ~d_pmem_write.
  - pmem_write=d_pmem_write.
  - pmem_address=d_pmem_address, pmem_wdata=d_pmem_wdata.
- pmem_wdata is 0 except in SERVE_D.
- Read data: i_pmem_rdata and d_pmem_rdata both carry pmem_rdata unconditionally; only resp is gated.
- Completion in SERVE_x:
  - pmem_resp=1 drives x_pmem_resp=1 combinationally in the same cycle.
  - The other requester's resp is never asserted.
  - Next state: DONE.
- State DONE:
  - One turnaround cycle; all pmem outputs 0; both resps 0.
  - Next state: IDLE.
  - Guarantees a cache's stale request, still high in the resp cycle, is never re-granted.
- Requester drops its request mid-SERVE (protocol violation):
  - The arbiter keeps the grant and drives its mux from the live inputs.
  - The bench flags it as an error; no recovery is required.
- pmem_resp outside SERVE_x is ignored.
- The non-granted requester waits with its request held; it has no timeout.
- Round-robin bounds wait: at most one full transaction of the other cache.
- rst asserted mid-transaction:
  - Immediate return to IDLE with reset values.
  - Any in-flight memory response after reset release is ignored, because the FSM is in IDLE.

Optional Feature:
- Macro: CACHE_ARBITER_DPRIO_EN
- Defined: fixed priority. On a tie in IDLE, D always wins. last_grant is still maintained but unused for arbitration.
- Undefined: round-robin as described above.

Decomposition:
- Shared package cache_arb_types:
  - enum arb_state_t {IDLE, SERVE_I, SERVE_D, DONE}
  - enum grant_t {GRANT_I, GRANT_D}
- The memory-side output mux is a small natural sub-module, arb_pmem_mux.
  - Inputs: the grant/state and both requester buses.
  - Outputs: the pmem_* outputs.
- The FSM stays in cache_arbiter.

Test Plan:
- Reset: assert rst mid-SERVE_D with pmem_write=1 -> pmem_write falls asynchronously to 0, state IDLE; no resp pulse after release.
- Lone icache: i_pmem_read=1, addr 0x0000_0040 at cycle 0 -> cycle 1 pmem_read=1, pmem_address=0x40. Memory resp at cycle 5 with rdata=256'hA5.. -> i_pmem_resp=1 in cycle 5 with matching data, d_pmem_resp=0. Cycle 6 idle outputs.
- Lone dcache write-back: d_pmem_write=1, addr 0x0000_1000, wdata=256'hDEADBEEF.. -> pmem_write=1, matching address and wdata, pmem_read=0. Completes with d_pmem_resp pulse.
- Tie, round-robin (macro undefined): both request from reset -> I served first, then D, then I again on the next tie. Grant order I,D,I.
- Tie, CACHE_ARBITER_DPRIO_EN defined: both request continuously for three transactions -> D wins every tie.
- Illegal d_pmem_read=d_pmem_write=1 -> pmem_write=1, pmem_read=0. Stale request still high in the resp cycle -> DONE cycle, then a fresh grant only if the request is still asserted in IDLE.
